// File: rtl/sad_min_select_pkg.sv
// Shared definitions for the SAD minimum selector: default geometry,
// the SAD width derivation, the array latency rule and the FSM encoding.
package sad_min_select_pkg;

  localparam int DEF_PIXELS_IN_BATCH = 16;
  localparam int DEF_LOG_PIXELS      = 4;
  localparam int DEF_LOG_EDGE_LEN    = 3;
  localparam int DEF_BIT_DEPTH       = 8;
  localparam int DEF_NUM_STEPS       = 16;
  localparam int DEF_LOG_NUM_STEPS   = 4;

  // Sum of EDGE_LEN^2 absolute differences of BIT_DEPTH-bit pixels.
  function automatic int sad_bits(input int log_edge_len, input int bit_depth);
    return 2 * log_edge_len + bit_depth;
  endfunction

  // The current systolic array takes two edge lengths to produce its first batch.
  function automatic int default_array_latency(input int log_edge_len);
    return 2 * (1 << log_edge_len);
  endfunction

  localparam int DEF_SAD_BITS      = sad_bits(DEF_LOG_EDGE_LEN, DEF_BIT_DEPTH);
  localparam int DEF_IDX_BITS      = DEF_LOG_NUM_STEPS + DEF_LOG_PIXELS;
  localparam int DEF_ARRAY_LATENCY = default_array_latency(DEF_LOG_EDGE_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sad_min_select_if.sv
// Bundle between the motion-vector controller / SAD array (master) and
// the minimum selector (slave).
interface sad_min_select_if
  import sad_min_select_pkg::*;
#(
  parameter int PIXELS_IN_BATCH = DEF_PIXELS_IN_BATCH,
  parameter int SAD_BITS        = DEF_SAD_BITS,
  parameter int IDX_BITS        = DEF_IDX_BITS
);

  logic                                start;
  logic [PIXELS_IN_BATCH*SAD_BITS-1:0] sad_in;
  logic                                busy;
  logic                                done;
  logic [SAD_BITS-1:0]                 best_sad;
  logic [IDX_BITS-1:0]                 best_index;

  modport master (
    output start, sad_in,
    input  busy, done, best_sad, best_index
  );

  modport slave (
    input  start, sad_in,
    output busy, done, best_sad, best_index
  );

endinterface

// File: rtl/sad_min_select_batch_min.sv
// Combinational minimum over one batch of lane SADs. Binary tree laid out
// heap-style: leaves hold lanes in ascending order, so a left child always
// covers lower lanes than its right sibling.
module sad_batch_min #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int SAD_BITS        = 14,
  parameter int LANE_BITS       = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1
) (
  input  logic [PIXELS_IN_BATCH*SAD_BITS-1:0] sad_in,
  output logic [SAD_BITS-1:0]                 min_sad,
  output logic [LANE_BITS-1:0]                min_lane
);

  localparam int NODES = 2 * PIXELS_IN_BATCH - 1;

  logic [SAD_BITS-1:0]  node_sad  [NODES];
  logic [LANE_BITS-1:0] node_lane [NODES];

  // Fill leaves from the lanes, then reduce towards the root; the right
  // child wins only when strictly smaller, so ties go to the lower lane.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    node_sad  = '{default: '0};
    node_lane = '{default: '0};
    for (int l = 0; l < PIXELS_IN_BATCH; l++) begin
      node_sad[PIXELS_IN_BATCH-1+l]  = sad_in[l*SAD_BITS +: SAD_BITS];
      node_lane[PIXELS_IN_BATCH-1+l] = LANE_BITS'(l);
    end
    for (int i = PIXELS_IN_BATCH - 2; i >= 0; i--) begin
      if (node_sad[2*i+2] < node_sad[2*i+1]) begin
        node_sad[i]  = node_sad[2*i+2];
        node_lane[i] = node_lane[2*i+2];
      end else begin
        node_sad[i]  = node_sad[2*i+1];
        node_lane[i] = node_lane[2*i+1];
      end
    end
    min_sad  = node_sad[0];
    min_lane = node_lane[0];
  end

endmodule

// File: rtl/sad_min_select.sv
// Consumer end of the motion-estimation SAD array: reduces each per-cycle
// batch to its minimum and keeps the running best over one search, then
// reports {best SAD, step, lane} with a one-cycle done pulse.
module sad_min_select
  import sad_min_select_pkg::*;
#(
  parameter int PIXELS_IN_BATCH = DEF_PIXELS_IN_BATCH,
  parameter int LOG_PIXELS      = DEF_LOG_PIXELS,
  parameter int LOG_EDGE_LEN    = DEF_LOG_EDGE_LEN,
  parameter int BIT_DEPTH       = DEF_BIT_DEPTH,
  parameter int ARRAY_LATENCY   = DEF_ARRAY_LATENCY,
  parameter int NUM_STEPS       = DEF_NUM_STEPS,
  parameter int LOG_NUM_STEPS   = DEF_LOG_NUM_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  sad_min_select_if.slave    bus
);

  localparam int SAD_BITS = sad_bits(LOG_EDGE_LEN, BIT_DEPTH);
  localparam int IDX_BITS = LOG_NUM_STEPS + LOG_PIXELS;
  localparam int FILL_W   = (ARRAY_LATENCY > 2) ? $clog2(ARRAY_LATENCY) : 1;

  localparam logic [FILL_W-1:0]        FILL_LAST = FILL_W'(ARRAY_LATENCY - 2);
  localparam logic [LOG_NUM_STEPS-1:0] STEP_LAST = LOG_NUM_STEPS'(NUM_STEPS - 1);

  state_t                   state;
  logic [FILL_W-1:0]        fill_cnt;
  logic [LOG_NUM_STEPS-1:0] step_cnt;

  // Stage 1: registered batch minimum with its position.
  logic                     s1_valid;
  logic [SAD_BITS-1:0]      s1_min;
  logic [LOG_PIXELS-1:0]    s1_lane;
  logic [LOG_NUM_STEPS-1:0] s1_step;

  // Stage 2: running best over the current search.
  logic [SAD_BITS-1:0]      run_sad;
  logic [IDX_BITS-1:0]      run_idx;

  logic [SAD_BITS-1:0]      batch_min;
  logic [LOG_PIXELS-1:0]    batch_lane;
  logic [SAD_BITS-1:0]      merged_sad;
  logic [IDX_BITS-1:0]      merged_idx;

  sad_batch_min #(
    .PIXELS_IN_BATCH (PIXELS_IN_BATCH),
    .SAD_BITS        (SAD_BITS),
    .LANE_BITS       (LOG_PIXELS)
  ) u_batch_min (
    .sad_in   (bus.sad_in),
    .min_sad  (batch_min),
    .min_lane (batch_lane)
  );

  // Running best folded with the pending stage-1 result; strict less-than
  // keeps the earlier step on ties.
  always_comb begin
    merged_sad = run_sad;
    merged_idx = run_idx;
    if (s1_valid && (s1_min < run_sad)) begin
      merged_sad = s1_min;
      merged_idx = {s1_step, s1_lane};
    end
  end

  // Search FSM with its counters, pipeline stages and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state          <= ST_IDLE;
      fill_cnt       <= '0;
      step_cnt       <= '0;
      s1_valid       <= 1'b0;
      s1_min         <= '0;
      s1_lane        <= '0;
      s1_step        <= '0;
      run_sad        <= '1;
      run_idx        <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.best_sad   <= '1;
      bus.best_index <= '0;
    end else begin
      bus.done <= 1'b0;
      s1_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state    <= (ARRAY_LATENCY == 1) ? ST_SCAN : ST_FILL;
            bus.busy <= 1'b1;
            fill_cnt <= '0;
            step_cnt <= '0;
            run_sad  <= '1;
            run_idx  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state <= ST_SCAN;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          s1_valid <= 1'b1;
          s1_min   <= batch_min;
          s1_lane  <= batch_lane;
          s1_step  <= step_cnt;
          run_sad  <= merged_sad;
          run_idx  <= merged_idx;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == STEP_LAST) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          run_sad        <= merged_sad;
          run_idx        <= merged_idx;
          bus.best_sad   <= merged_sad;
          bus.best_index <= merged_idx;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select with default parameters.
module tb_sad_min_select;
  import sad_min_select_pkg::*;

  localparam int P    = 16;
  localparam int SB   = 14;
  localparam int IDXB = 8;
  localparam int L    = 16;
  localparam int N    = 16;
  localparam int DONE_C = L + N + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_min_select_if #(.PIXELS_IN_BATCH(P), .SAD_BITS(SB), .IDX_BITS(IDXB)) bus ();

  sad_min_select dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pattern description: background value plus up to two special points.
  int bg;
  int sp_step [2];
  int sp_lane [2];
  int sp_val  [2];

  logic [SB-1:0]   held_sad;
  logic [IDXB-1:0] held_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P*SB-1:0] make_batch(input int step);
    logic [P*SB-1:0] b;
    int v;
    b = '0;
    for (int l = 0; l < P; l++) begin
      v = bg;
      for (int j = 0; j < 2; j++)
        if (sp_step[j] == step && sp_lane[j] == l) v = sp_val[j];
      b[l*SB +: SB] = SB'(v);
    end
    return b;
  endfunction

  task automatic set_pattern(input int b, input int s0, input int l0, input int v0,
                             input int s1, input int l1, input int v1);
    bg = b;
    sp_step[0] = s0; sp_lane[0] = l0; sp_val[0] = v0;
    sp_step[1] = s1; sp_lane[1] = l1; sp_val[1] = v1;
  endtask

  // Starts a search in the current cycle and follows it to its DONE cycle.
  // Zero garbage is driven outside SCAN; it would win if it were sampled.
  task automatic run_search(input string tag, input int repulse_c,
                            input int exp_sad, input int exp_idx);
    bus.start  = 1'b1;
    bus.sad_in = '0;
    for (int c = 1; c <= DONE_C; c++) begin
      tick();
      bus.start  = (c == repulse_c);
      bus.sad_in = (c >= L && c < L + N) ? make_batch(c - L) : '0;
      check({tag, ".done"}, bus.done, c == DONE_C);
      check({tag, ".busy"}, bus.busy, c <= L + N);
      if (c == DONE_C) begin
        held_sad = SB'(exp_sad);
        held_idx = IDXB'(exp_idx);
      end
      check({tag, ".best_sad"}, bus.best_sad, held_sad);
      check({tag, ".best_index"}, bus.best_index, held_idx);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.start  = 1'b0;
      bus.sad_in = {P{SB'($urandom)}};
      check({tag, ".done"}, bus.done, 1'b0);
      check({tag, ".busy"}, bus.busy, 1'b0);
      check({tag, ".best_sad"}, bus.best_sad, held_sad);
      check({tag, ".best_index"}, bus.best_index, held_idx);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.sad_in = '0;
    set_pattern(0, -1, 0, 0, -1, 0, 0);
    repeat (3) tick();
    check("reset.busy", bus.busy, 1'b0);
    check("reset.done", bus.done, 1'b0);
    check("reset.best_sad", bus.best_sad, 16383);
    check("reset.best_index", bus.best_index, 0);
    rst      = 1'b0;
    held_sad = 14'd16383;
    held_idx = 8'd0;
    idle("post_reset", 2);

    // Every candidate equal: first candidate wins.
    set_pattern(100, -1, 0, 0, -1, 0, 0);
    run_search("all100", -1, 100, 0);
    idle("gap1", 3);

    // Single minimum in the middle of the search.
    set_pattern(500, 5, 9, 3, -1, 0, 0);
    run_search("single", -1, 3, 89);
    idle("gap2", 2);

    // Equal minima in different steps: earlier step wins.
    set_pattern(8, 2, 15, 7, 10, 0, 7);
    run_search("tie_step", -1, 7, 47);
    idle("gap3", 2);

    // Full-width background with the last candidate at zero; start
    // re-pulsed during SCAN must be ignored.
    set_pattern(16383, 15, 15, 0, -1, 0, 0);
    run_search("maxbg", 20, 0, 255);

    // Back-to-back: start driven in the DONE cycle of the previous search.
    set_pattern(200, 7, 3, 50, -1, 0, 0);
    run_search("b2b", -1, 50, 115);
    idle("gap4", 3);

    // Reset asserted in cycle T+20: no done, outputs back to reset values.
    set_pattern(1, -1, 0, 0, -1, 0, 0);
    bus.start  = 1'b1;
    bus.sad_in = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start  = 1'b0;
      bus.sad_in = (c >= L) ? make_batch(c - L) : '0;
      check("rst_mid.busy", bus.busy, 1'b1);
      check("rst_mid.done", bus.done, 1'b0);
      check("rst_mid.best_sad", bus.best_sad, held_sad);
    end
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    held_sad = 14'd16383;
    held_idx = 8'd0;
    check("rst_mid.busy_after", bus.busy, 1'b0);
    check("rst_mid.best_sad_after", bus.best_sad, 16383);
    check("rst_mid.best_index_after", bus.best_index, 0);
    idle("rst_quiet", 20);

    // Equal minima in two lanes of one batch: lower lane wins.
    set_pattern(8, 3, 12, 1, 3, 4, 1);
    run_search("tie_lane", -1, 1, 52);
    idle("tail", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sad_min_select.md
# sad_min_select

Consumer end of the motion-estimation SAD array: samples the per-cycle batch of `PIXELS_IN_BATCH` candidate SADs the array emits, reduces each batch to its minimum, and tracks the running minimum across one full search. At the end of a search it reports the best SAD and its candidate index to the motion-vector controller. It sits directly downstream of the systolic AD/A array and is started by the same controller that starts feeding reference columns.

## Interface
- `PIXELS_IN_BATCH`, 16: candidate SADs per cycle (lanes).
- `LOG_PIXELS`, 4: log2(`PIXELS_IN_BATCH`).
- `LOG_EDGE_LEN`, 3: log2 of the block edge length.
- `BIT_DEPTH`, 8: pixel bit depth.
- `ARRAY_LATENCY`, 16: cycles from `start` to the first valid SAD batch; must be ≥1.
- `NUM_STEPS`, 16: valid SAD batches per search.
- `LOG_NUM_STEPS`, 4: log2(`NUM_STEPS`).
- Derived `SAD_BITS` = 2*`LOG_EDGE_LEN`+`BIT_DEPTH` (14); `IDX_BITS` = `LOG_NUM_STEPS`+`LOG_PIXELS`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse marking the cycle the first reference column enters the array.
- `sad_in`  in  `PIXELS_IN_BATCH`*`SAD_BITS`  SAD batch; lane l is `sad_in[(l+1)*SAD_BITS-1 : l*SAD_BITS]`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `best_*` are valid and stable from this cycle.
- `best_sad`  out  `SAD_BITS`  minimum SAD of the last completed search.
- `best_index`  out  `IDX_BITS`  {step, lane} of that minimum.

## Operation
- FSM states: IDLE, FILL, SCAN, FLUSH, DONE.
- IDLE: `start` = 1 moves the FSM to FILL, clears the cycle counter and sets the running best to all-ones with index 0.
- FILL: counts `ARRAY_LATENCY`-1 cycles, then moves to SCAN. `sad_in` is ignored.
- SCAN: lasts exactly `NUM_STEPS` cycles, with the step counter running 0..`NUM_STEPS`-1. Each cycle samples `sad_in` into the stage-1 reducer.
- FLUSH: one cycle that drains the final stage-1 result into the running best.
- DONE: copies the running best to `best_sad` and `best_index` and pulses `done`, then returns to IDLE.
- Stage 1 (batch min): a combinational tree over the lanes picks the minimum. On ties the lower lane wins. It registers {min, lane, step}.
- Stage 2 (running best): replaces the running best only if the stage-1 min is strictly less than it. Ties therefore keep the earlier step.
- Net result: the lowest candidate index wins among equal SADs.
- Comparisons are unsigned and at full `SAD_BITS` width. There is no saturation and no truncation.
- `start` is accepted in IDLE and DONE, so back-to-back searches work. It is ignored in FILL, SCAN and FLUSH.
- `rst` mid-search returns the FSM to IDLE with no `done` pulse.

## Timing
- Reset values: `busy` = 0, `done` = 0, `best_sad` = all-ones, `best_index` = 0, FSM = IDLE, counters = 0.
- `start` is sampled at cycle T.
- `sad_in` step k is sampled at cycle T+`ARRAY_LATENCY`+k, for k = 0..`NUM_STEPS`-1.
- `done` is high at cycle T+`ARRAY_LATENCY`+`NUM_STEPS`+1.
- `busy` is high in cycles T+1 through T+`ARRAY_LATENCY`+`NUM_STEPS`, i.e. FILL, SCAN and FLUSH.
- `best_*` change only in the DONE cycle and hold until the next DONE.
- A back-to-back `start` in the DONE cycle counts as the next cycle T.
- `sad_in` is never stalled, because the array runs every cycle. There is no valid or ready handshake.

## Structure
- Shared header `me_defs.vh` holds:
  - the `SAD_BITS` derivation;
  - the FSM state encodings (3-bit);
  - the default `ARRAY_LATENCY` rule (2*EDGE_LEN for the current array).
- Sub-module `sad_batch_min`:
  - parameterised by `PIXELS_IN_BATCH` and `SAD_BITS`;
  - a combinational lane-min tree with lowest-lane tie-break;
  - outputs {min, lane}.
- The top level holds the FSM, the counters, the stage-1/2 registers and the output registers.

## Test plan
- All lanes and steps equal to 100 -> `best_sad` = 100, `best_index` = 0, `done` exactly at T+33 (defaults).
- Background 500; step 5 lane 9 = 3 -> `best_sad` = 3, `best_index` = 89.
- Value 7 at step 2 lane 15 and at step 10 lane 0, background 8 -> `best_index` = 47 (earliest wins).
- All SADs 16383 except step 15 lane 15 = 0 -> `best_sad` = 0, `best_index` = 255. Also check that garbage on `sad_in` during FILL and FLUSH is ignored.
- `start` re-pulsed during SCAN -> ignored, single `done`. `rst` asserted at T+20 -> no `done`, outputs at reset values. Back-to-back `start` on `done` -> second `done` 33 cycles later with new results.
